// File: rtl/r4u_twiddle_mul_pkg.sv
// r4u_twiddle_mul_pkg: shared widths, quarter-wave table generator and symmetric rounding
package r4u_twiddle_mul_pkg;
  localparam int MAN_WIDTH = 12;
  localparam int EXP_WIDTH = 6;
  localparam int TW_WIDTH = 16;
  localparam int LDN_MAX = 11;
  localparam int N3_WIDTH = LDN_MAX - 2;
  localparam int TBL_DEPTH = 2 ** (LDN_MAX - 2) + 1;
  localparam int PRD_WIDTH = MAN_WIDTH + TW_WIDTH;
  localparam int SUM_WIDTH = PRD_WIDTH + 1;
  localparam int MAN_MAX = 2 ** (MAN_WIDTH - 1) - 1;
  localparam real PI = 3.14159265358979323846;

  function automatic int tbl_val(input int k);
    return $rtoi($floor($cos(PI * k / (2.0 ** (LDN_MAX - 1))) * (2.0 ** (TW_WIDTH - 2)) + 0.5));
  endfunction

  // round half away from zero, shared with the butterfly stages
  function automatic logic signed [SUM_WIDTH-1:0] symrnd(input logic signed [SUM_WIDTH-1:0] x, input int sh);
    logic signed [SUM_WIDTH-1:0] half, neg;
    half = SUM_WIDTH'(1) << (sh - 1);
    neg = SUM_WIDTH'(x[SUM_WIDTH-1]);
    return (x + half - neg) >>> sh;
  endfunction
endpackage

// File: rtl/r4u_twiddle_mul_if.sv
// r4u_twiddle_mul_if: sample stream from butterfly stage II into the next unit's stage I
interface r4u_twiddle_mul_if;
  import r4u_twiddle_mul_pkg::*;
  logic block_sync_i, next_sync_i, data_val_i, k1_i, k2_i;
  logic signed [MAN_WIDTH-1:0] data_real_i, data_imag_i;
  logic signed [EXP_WIDTH-1:0] data_exp_i;
  logic [3:0] ldn_loc_i;
  logic block_sync_o, stage_sync_o, data_val_o;
  logic signed [MAN_WIDTH-1:0] data_real_o, data_imag_o;
  logic signed [EXP_WIDTH-1:0] data_exp_o;
  modport master (
    output block_sync_i, next_sync_i, data_val_i, k1_i, k2_i, data_real_i, data_imag_i, data_exp_i, ldn_loc_i,
    input block_sync_o, stage_sync_o, data_val_o, data_real_o, data_imag_o, data_exp_o
  );
  modport slave (
    input block_sync_i, next_sync_i, data_val_i, k1_i, k2_i, data_real_i, data_imag_i, data_exp_i, ldn_loc_i,
    output block_sync_o, stage_sync_o, data_val_o, data_real_o, data_imag_o, data_exp_o
  );
endinterface

// File: rtl/r4_twiddle_rom.sv
// r4_twiddle_rom: registered cos/sin lookup for phase p via quarter-wave table and quadrant mapping
module r4_twiddle_rom
  import r4u_twiddle_mul_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic [LDN_MAX-1:0] p,
  output logic signed [TW_WIDTH-1:0] c,
  output logic signed [TW_WIDTH-1:0] s
);
  localparam int IW = LDN_MAX - 1;
  localparam logic [IW-1:0] QTR = IW'(TBL_DEPTH - 1);
  logic signed [TW_WIDTH-1:0] tbl [TBL_DEPTH];
  logic [1:0] q;
  logic [IW-1:0] i, j;
  for (genvar k = 0; k < TBL_DEPTH; k++) begin : g_tbl
    localparam logic signed [TW_WIDTH-1:0] V = TW_WIDTH'(tbl_val(k));
    assign tbl[k] = V;
  end
  assign q = p[LDN_MAX-1 -: 2];
  assign i = {1'b0, p[LDN_MAX-3:0]};
  assign j = QTR - i;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      c <= '0;
      s <= '0;
    end else begin
      c <= q == 2'd0 ? tbl[i] : q == 2'd1 ? -tbl[j] : q == 2'd2 ? -tbl[i] : tbl[j];
      s <= q == 2'd0 ? tbl[j] : q == 2'd1 ? tbl[i] : q == 2'd2 ? -tbl[j] : -tbl[i];
    end
endmodule

// File: rtl/r4u_twiddle_mul.sv
// r4u_twiddle_mul: 3-stage twiddle multiply with block-floating-point renormalisation
module r4u_twiddle_mul
  import r4u_twiddle_mul_pkg::*;
(
  input logic clk_sys,
  input logic rst_sys,
  r4u_twiddle_mul_if.slave bus
);
  logic start, v1, bs1, ss1, byp1, v2, bs2, ss2, byp2, ovf;
  logic [N3_WIDTH-1:0] n3_q, n3_cur, n3_last;
  logic [1:0] m_q, m_cur;
  logic [LDN_MAX-1:0] prod, p;
  logic signed [MAN_WIDTH-1:0] a1, b1, a2, b2;
  logic signed [EXP_WIDTH-1:0] e1, e2;
  logic signed [TW_WIDTH-1:0] c1, s1;
  logic signed [PRD_WIDTH-1:0] p_ac, p_bs, p_bc, p_as;
  logic signed [SUM_WIDTH-1:0] re_r, im_r;

  // the sample carrying next_sync already uses n3=0 and the new multiplier
  assign start = bus.data_val_i & bus.next_sync_i;
  assign n3_cur = start ? '0 : n3_q;
  assign m_cur = start ? {bus.k2_i, bus.k1_i} : m_q;
  assign n3_last = N3_WIDTH'((32'd1 << (bus.ldn_loc_i - 4'd2)) - 32'd1);
  assign prod = LDN_MAX'(n3_cur) * LDN_MAX'(m_cur);
  assign p = prod << (4'(LDN_MAX) - bus.ldn_loc_i);

  always_ff @(posedge clk_sys or posedge rst_sys)
    if (rst_sys) begin
      n3_q <= '0;
      m_q <= '0;
    end else if (bus.data_val_i) begin
      n3_q <= n3_cur == n3_last ? '0 : n3_cur + 1'b1;
      m_q <= m_cur;
    end

  r4_twiddle_rom rom (.clk(clk_sys), .rst(rst_sys), .p(p), .c(c1), .s(s1));

  always_ff @(posedge clk_sys or posedge rst_sys)
    if (rst_sys) begin
      {v1, bs1, ss1, byp1} <= '0;
      a1 <= '0;
      b1 <= '0;
      e1 <= '0;
    end else begin
      v1 <= bus.data_val_i;
      bs1 <= bus.data_val_i & bus.block_sync_i;
      ss1 <= start;
      byp1 <= p == '0;
      a1 <= bus.data_real_i;
      b1 <= bus.data_imag_i;
      e1 <= bus.data_exp_i;
    end

  always_ff @(posedge clk_sys or posedge rst_sys)
    if (rst_sys) begin
      {v2, bs2, ss2, byp2} <= '0;
      a2 <= '0;
      b2 <= '0;
      e2 <= '0;
      {p_ac, p_bs, p_bc, p_as} <= '0;
    end else begin
      {v2, bs2, ss2, byp2} <= {v1, bs1, ss1, byp1};
      a2 <= a1;
      b2 <= b1;
      e2 <= e1;
      p_ac <= a1 * c1;
      p_bs <= b1 * s1;
      p_bc <= b1 * c1;
      p_as <= a1 * s1;
    end

  assign re_r = symrnd(SUM_WIDTH'(p_ac) + SUM_WIDTH'(p_bs), TW_WIDTH - 2);
  assign im_r = symrnd(SUM_WIDTH'(p_bc) - SUM_WIDTH'(p_as), TW_WIDTH - 2);
  assign ovf = re_r > SUM_WIDTH'(MAN_MAX) || re_r < -SUM_WIDTH'(MAN_MAX) ||
               im_r > SUM_WIDTH'(MAN_MAX) || im_r < -SUM_WIDTH'(MAN_MAX);

  always_ff @(posedge clk_sys or posedge rst_sys)
    if (rst_sys) begin
      {bus.data_val_o, bus.block_sync_o, bus.stage_sync_o} <= '0;
      bus.data_real_o <= '0;
      bus.data_imag_o <= '0;
      bus.data_exp_o <= '0;
    end else begin
      bus.data_val_o <= v2;
      bus.block_sync_o <= v2 & bs2;
      bus.stage_sync_o <= v2 & ss2;
      bus.data_real_o <= !v2 ? '0 : byp2 ? a2 : MAN_WIDTH'(ovf ? symrnd(re_r, 1) : re_r);
      bus.data_imag_o <= !v2 ? '0 : byp2 ? b2 : MAN_WIDTH'(ovf ? symrnd(im_r, 1) : im_r);
      bus.data_exp_o <= !v2 ? '0 : (byp2 || !ovf) ? e2 : e2 + 1'b1;
    end
endmodule

// File: tb/tb_r4u_twiddle_mul.sv
// tb_r4u_twiddle_mul: random and directed stream checked against a real-arithmetic twiddle model
module tb_r4u_twiddle_mul;
  import r4u_twiddle_mul_pkg::*;
  logic clk_sys = 0;
  logic rst_sys = 1;
  r4u_twiddle_mul_if bus();
  r4u_twiddle_mul dut (.clk_sys(clk_sys), .rst_sys(rst_sys), .bus(bus));
  always #5 clk_sys = ~clk_sys;

  int total = 0, bad = 0;
  bit chk_en = 0;
  logic [32:0] exp_q[$];
  string tag_q[$];
  string tag = "init";
  int n3 = 0, m = 0;

  task automatic check(string name, logic [32:0] got, logic [32:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic logic [32:0] dut_out();
    return {bus.data_val_o, bus.block_sync_o, bus.stage_sync_o, bus.data_real_o, bus.data_imag_o, bus.data_exp_o};
  endfunction

  function automatic longint rnd(longint x, int sh);
    longint h = longint'(1) << (sh - 1);
    return x < 0 ? -((-x + h) / (2 * h)) : (x + h) / (2 * h);
  endfunction

  function automatic longint coef(real x);
    return x < 0.0 ? -longint'($rtoi($floor(-x + 0.5))) : longint'($rtoi($floor(x + 0.5)));
  endfunction

  function automatic int ra();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  function automatic longint mag(longint x);
    return x < 0 ? -x : x;
  endfunction

  task automatic idle();
    {bus.block_sync_i, bus.next_sync_i, bus.data_val_i, bus.k1_i, bus.k2_i} = '0;
    bus.data_real_i = '0;
    bus.data_imag_i = '0;
    bus.data_exp_i = '0;
  endtask

  task automatic drive(bit v, bit bsy, bit ns, int a, int b, int e, int ldn, bit k1, bit k2);
    int p, oe;
    longint c, s, re, im;
    real th;
    @(posedge clk_sys);
    #1;
    bus.data_val_i = v;
    bus.block_sync_i = bsy;
    bus.next_sync_i = ns;
    bus.data_real_i = MAN_WIDTH'(a);
    bus.data_imag_i = MAN_WIDTH'(b);
    bus.data_exp_i = EXP_WIDTH'(e);
    bus.ldn_loc_i = 4'(ldn);
    bus.k1_i = k1;
    bus.k2_i = k2;
    tag_q.push_back(tag);
    if (!v) begin
      exp_q.push_back('0);
      return;
    end
    if (ns) begin
      n3 = 0;
      m = k1 + 2 * k2;
    end
    p = ((n3 * m) << (LDN_MAX - ldn)) % (1 << LDN_MAX);
    n3 = (n3 + 1 == (1 << (ldn - 2))) ? 0 : n3 + 1;
    re = a;
    im = b;
    oe = e;
    if (p != 0) begin
      th = 2.0 * PI * p / (2.0 ** LDN_MAX);
      c = coef($cos(th) * (2.0 ** (TW_WIDTH - 2)));
      s = coef($sin(th) * (2.0 ** (TW_WIDTH - 2)));
      re = rnd(a * c + b * s, TW_WIDTH - 2);
      im = rnd(b * c - a * s, TW_WIDTH - 2);
      if (mag(re) > MAN_MAX || mag(im) > MAN_MAX) begin
        re = rnd(re, 1);
        im = rnd(im, 1);
        oe = e + 1;
      end
    end
    exp_q.push_back({1'b1, bsy, ns, MAN_WIDTH'(re), MAN_WIDTH'(im), EXP_WIDTH'(oe)});
  endtask

  // reset lands mid-cycle so in-flight samples are dropped asynchronously
  task automatic do_reset();
    @(posedge clk_sys);
    #3;
    rst_sys = 1;
    chk_en = 0;
    idle();
    #1;
    check("reset", dut_out(), '0);
    repeat (2) @(posedge clk_sys);
    #1;
    check("reset_hold", dut_out(), '0);
    rst_sys = 0;
    exp_q.delete();
    tag_q.delete();
    repeat (3) begin
      exp_q.push_back('0);
      tag_q.push_back("after_reset");
    end
    n3 = 0;
    m = 0;
    chk_en = 1;
  endtask

  task automatic rand_block(int ldn);
    int q4, len;
    bit k1, k2;
    q4 = 1 << (ldn - 2);
    for (int q = 0; q < 4; q++) begin
      len = $urandom_range(0, 7) == 0 ? int'($urandom_range(1, q4)) : q4;
      k1 = bit'($urandom_range(0, 1));
      k2 = bit'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) begin
        while ($urandom_range(0, 3) == 0)
          drive(0, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), ra(), ra(), 0, ldn,
                bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        drive(1, q == 0 && i == 0, i == 0, ra(), ra(), int'($urandom_range(0, 63)) - 32, ldn, k1, k2);
      end
    end
  endtask

  always @(negedge clk_sys)
    if (chk_en && exp_q.size() > 3)
      check(tag_q.pop_front(), dut_out(), exp_q.pop_front());

  initial begin
    int ldns[9] = '{4, 5, 6, 7, 8, 9, 11, 10, 4};
    idle();
    bus.ldn_loc_i = 4'd4;
    do_reset();
    tag = "bypass";
    drive(1, 1, 1, 1000, -300, 2, 4, 0, 0);
    repeat (3) drive(1, 0, 0, 1000, -300, 2, 4, 0, 0);
    tag = "m1_l16";
    drive(1, 0, 1, 1000, 0, 0, 4, 1, 0);
    drive(1, 0, 0, 1000, 0, 0, 4, 1, 0);
    drive(1, 0, 0, -700, 1234, 5, 4, 1, 0);
    drive(1, 0, 0, 2047, -2048, 5, 4, 1, 0);
    tag = "m2_minus_j";
    drive(1, 0, 1, 1000, 500, 1, 4, 0, 1);
    repeat (3) drive(1, 0, 0, 1000, 500, 1, 4, 0, 1);
    tag = "ovf_l8";
    drive(1, 1, 1, 2047, 2047, 3, 3, 1, 0);
    drive(1, 0, 0, 2047, 2047, 3, 3, 1, 0);
    drive(1, 0, 0, 2047, 2047, 3, 3, 1, 0);
    drive(1, 0, 0, -2048, -2048, 31, 3, 1, 0);
    tag = "gaps_resync";
    drive(1, 1, 1, 300, -200, 0, 6, 1, 1);
    for (int i = 0; i < 12; i++) begin
      if (i % 3 == 1) drive(0, 0, 1, 0, 0, 0, 6, 0, 0);
      drive(1, 0, 0, ra(), ra(), 1, 6, 1, 1);
    end
    drive(1, 0, 1, ra(), ra(), 1, 6, 1, 0);
    repeat (5) drive(1, 0, 0, ra(), ra(), -2, 6, 1, 0);
    tag = "pre_reset";
    drive(1, 1, 1, ra(), ra(), 0, 5, 1, 1);
    repeat (3) drive(1, 0, 0, ra(), ra(), 0, 5, 1, 1);
    do_reset();
    tag = "post_reset_m0";
    repeat (4) drive(1, 0, 0, ra(), ra(), 7, 5, 1, 1);
    tag = "random";
    foreach (ldns[i]) rand_block(ldns[i]);
    tag = "drain";
    repeat (4) drive(0, 0, 0, 0, 0, 0, 4, 0, 0);
    @(negedge clk_sys);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
